// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready), flush-to-bubble and a saturating back-pressure counter.
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    Empty = 2'd0,
    Busy  = 2'd1,
    Full  = 2'd2
  } StateT;

  generate
    if (SKID != 0) begin : gSkid
      StateT            state;
      StateT            nextState;
      logic [WIDTH-1:0] mainQ;
      logic [WIDTH-1:0] skidQ;
      logic [WIDTH-1:0] mainNext;
      logic [WIDTH-1:0] skidNext;

      // in_ready depends only on state, so it never combines with out_ready
      assign out_valid = (state != Empty);
      assign in_ready  = (state != Full) & ~reset;
      assign out_data  = mainQ;

      // Flush overrides whatever transfer the state machine would have made
      always_comb begin
        nextState = state;
        mainNext  = mainQ;
        skidNext  = skidQ;
        case (state)
          Empty: begin
            if (in_valid) begin
              mainNext  = in_data;
              nextState = Busy;
            end
          end
          Busy: begin
            if (in_valid && out_ready) begin
              mainNext = in_data;
            end else if (in_valid) begin
              skidNext  = in_data;
              nextState = Full;
            end else if (out_ready) begin
              nextState = Empty;
            end
          end
          Full: begin
            if (out_ready) begin
              mainNext  = skidQ;
              nextState = Busy;
            end
          end
          default: nextState = Empty;
        endcase
        if (flush) begin
          nextState = Empty;
          mainNext  = '0;
          skidNext  = '0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state <= Empty;
          mainQ <= '0;
          skidQ <= '0;
        end else begin
          state <= nextState;
          mainQ <= mainNext;
          skidQ <= skidNext;
        end
      end
    end else begin : gSingle
      logic             validQ;
      logic [WIDTH-1:0] mainQ;

      // Single entry: accept when empty or when the held entry leaves this cycle
      assign in_ready  = (~validQ | out_ready) & ~reset;
      assign out_valid = validQ;
      assign out_data  = mainQ;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          validQ <= 1'b0;
          mainQ  <= '0;
        end else if (flush) begin
          validQ <= 1'b0;
          mainQ  <= '0;
        end else if (in_valid && in_ready) begin
          validQ <= 1'b1;
          mainQ  <= in_data;
        end else if (validQ && out_ready) begin
          validQ <= 1'b0;
        end
      end
    end
  endgenerate

  // Back-pressure counter keeps counting through flush and sticks at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
